ioq_hdr_inserter: RTL and testbench

//  Rx-side writer of the IOQ module header; later pipeline stages parse and rewrite this header.

---
 rtl/ioq_hdr_inserter_pkg.sv | 43 ++++
 rtl/ioq_hdr_inserter_if.sv | 13 +
 rtl/fallthrough_small_fifo.sv | 49 ++++
 rtl/ioq_pkt_len_counter.sv | 86 ++++++++
 rtl/ioq_hdr_inserter.sv | 148 ++++++++++++++
 tb/tb_ioq_hdr_inserter.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/ioq_hdr_inserter_pkg.sv
// Shared types, IOQ header field layout and helpers for the rx header inserter.
package ioq_hdr_inserter_pkg;

  localparam logic [7:0]  IoQueueStageNum = 8'hff;
  localparam int unsigned IoqDstPortPos   = 48;
  localparam int unsigned IoqWordLenPos   = 32;
  localparam int unsigned IoqSrcPortPos   = 16;
  localparam int unsigned IoqByteLenPos   = 0;

  typedef enum logic [1:0] {
    RdIdle,
    RdHdr,
    RdBody
  } rd_state_e;

  typedef struct packed {
    logic [15:0] word_len;
    logic [15:0] byte_len;
  } pkt_len_t;

  // Valid bytes in the final word: 8 minus the index of the lowest set ctrl bit.
  function automatic logic [3:0] ctrl_last_bytes(input logic [7:0] ctrl);
    logic [3:0] n;
    n = '0;
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i]) n = 4'(8 - i);
    end
    return n;
  endfunction

  function automatic logic [63:0] ioq_hdr(input logic [15:0] word_len,
                                          input logic [15:0] src_port,
                                          input logic [15:0] byte_len);
    logic [63:0] h;
    h = '0;
    h[IoqDstPortPos +: 16] = 16'h0000;
    h[IoqWordLenPos +: 16] = word_len;
    h[IoqSrcPortPos +: 16] = src_port;
    h[IoqByteLenPos +: 16] = byte_len;
    return h;
  endfunction

endpackage

// File: rtl/ioq_hdr_inserter_if.sv
// Word-wide packet stream with NetFPGA-style wr/rdy handshake.
interface ioq_hdr_inserter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout_o shows the head entry whenever not empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             nearly_full_o,
  output logic             empty_o
);
  localparam int unsigned Depth = 1 << MAX_DEPTH_BITS;

  typedef logic [MAX_DEPTH_BITS-1:0] ptr_t;
  typedef logic [MAX_DEPTH_BITS:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [Depth];
  ptr_t             wr_ptr_q, rd_ptr_q;
  cnt_t             count_q;
  logic             do_wr, do_rd;

  assign do_wr         = wr_en_i & ~full_o;
  assign do_rd         = rd_en_i & ~empty_o;
  assign dout_o        = mem_q[rd_ptr_q];
  assign full_o        = (count_q == cnt_t'(Depth));
  assign nearly_full_o = (count_q >= cnt_t'(Depth - 1));
  assign empty_o       = (count_q == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + cnt_t'(do_wr) - cnt_t'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ioq_pkt_len_counter.sv
// Write-side packet measurement: word/byte length, truncation at the word limit and tail drop.
module ioq_pkt_len_counter
  import ioq_hdr_inserter_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH    = 8,
  parameter int unsigned MAX_PKT_WORDS = 192
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  store_o,
  output logic [CTRL_WIDTH-1:0] store_ctrl_o,
  output logic                  len_push_o,
  output pkt_len_t              len_o,
  output logic                  trunc_o
);
  localparam logic [15:0]           MaxWords  = 16'(MAX_PKT_WORDS);
  localparam logic [15:0]           MaxBytes  = 16'(8 * MAX_PKT_WORDS);
  localparam logic [CTRL_WIDTH-1:0] TruncCtrl = CTRL_WIDTH'(1);

  logic [15:0] word_cnt_q, word_cnt_d, cnt_inc;
  logic        drop_q, drop_d;
  logic        len_push_q, len_push_d;
  logic        trunc_q, trunc_d;
  pkt_len_t    len_q, len_d;
  logic        last_word;

  assign cnt_inc   = word_cnt_q + 16'd1;
  assign last_word = |ctrl_i;

  always_comb begin
    word_cnt_d   = word_cnt_q;
    drop_d       = drop_q;
    len_push_d   = 1'b0;
    len_d        = len_q;
    trunc_d      = 1'b0;
    store_o      = 1'b0;
    store_ctrl_o = ctrl_i;
    if (wr_i) begin
      if (drop_q) begin
        if (last_word) drop_d = 1'b0;
      end else begin
        store_o = 1'b1;
        if (last_word) begin
          len_push_d     = 1'b1;
          len_d.word_len = cnt_inc;
          // 8*(word_cnt-1) with word_cnt counting this word is 8*word_cnt_q
          len_d.byte_len = (word_cnt_q << 3) + 16'(ctrl_last_bytes(8'(ctrl_i)));
          word_cnt_d     = '0;
        end else if (cnt_inc == MaxWords) begin
          store_ctrl_o   = TruncCtrl;
          len_push_d     = 1'b1;
          len_d.word_len = MaxWords;
          len_d.byte_len = MaxBytes;
          trunc_d        = 1'b1;
          drop_d         = 1'b1;
          word_cnt_d     = '0;
        end else begin
          word_cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_cnt_q <= '0;
      drop_q     <= 1'b0;
      len_push_q <= 1'b0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_q     <= drop_d;
      len_push_q <= len_push_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
    end
  end

  assign len_push_o = len_push_q;
  assign len_o      = len_q;
  assign trunc_o    = trunc_q;

endmodule

// File: rtl/ioq_hdr_inserter.sv
// Buffers rx packets, measures them, and emits an IOQ header word ahead of each unmodified body.
module ioq_hdr_inserter
  import ioq_hdr_inserter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter logic [15:0] SRC_PORT             = 16'd0,
  parameter int unsigned MAX_PKT_WORDS        = 192,
  parameter int unsigned DATA_FIFO_DEPTH_BITS = 9,
  parameter int unsigned LEN_FIFO_DEPTH_BITS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  ioq_hdr_inserter_if.slave      in_bus,
  ioq_hdr_inserter_if.master     out_bus,
  output logic                   pkt_truncated
);
  localparam int unsigned DataFifoW = CTRL_WIDTH + DATA_WIDTH;

  logic                  in_wr_ok;
  logic                  store;
  logic [CTRL_WIDTH-1:0] store_ctrl;
  logic                  len_push, len_wr;
  pkt_len_t              len_in, len_head;
  logic [31:0]           len_dout;
  logic                  len_full, len_nf, len_empty, len_pop;
  logic [DataFifoW-1:0]  data_dout;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  data_full, data_nf, data_empty, data_pop;

  rd_state_e             state_q, state_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

  // Writes past in_rdy are still taken while the data FIFO has room.
  assign in_wr_ok   = in_bus.wr & ~data_full;
  assign in_bus.rdy = ~data_nf & ~len_nf;

  ioq_pkt_len_counter #(
    .CTRL_WIDTH   (CTRL_WIDTH),
    .MAX_PKT_WORDS(MAX_PKT_WORDS)
  ) u_len_cnt (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_i        (in_wr_ok),
    .ctrl_i      (in_bus.ctrl),
    .store_o     (store),
    .store_ctrl_o(store_ctrl),
    .len_push_o  (len_push),
    .len_o       (len_in),
    .trunc_o     (pkt_truncated)
  );

  fallthrough_small_fifo #(
    .WIDTH         (DataFifoW),
    .MAX_DEPTH_BITS(DATA_FIFO_DEPTH_BITS)
  ) u_data_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .din_i        ({store_ctrl, in_bus.data}),
    .wr_en_i      (store),
    .rd_en_i      (data_pop),
    .dout_o       (data_dout),
    .full_o       (data_full),
    .nearly_full_o(data_nf),
    .empty_o      (data_empty)
  );

  assign len_wr = len_push & ~len_full;

  fallthrough_small_fifo #(
    .WIDTH         (32),
    .MAX_DEPTH_BITS(LEN_FIFO_DEPTH_BITS)
  ) u_len_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .din_i        (len_in),
    .wr_en_i      (len_wr),
    .rd_en_i      (len_pop),
    .dout_o       (len_dout),
    .full_o       (len_full),
    .nearly_full_o(len_nf),
    .empty_o      (len_empty)
  );

  assign len_head  = pkt_len_t'(len_dout);
  assign head_data = data_dout[DATA_WIDTH-1:0];
  assign head_ctrl = data_dout[DATA_WIDTH +: CTRL_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RdIdle;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RdIdle: if (!len_empty) state_d = RdHdr;
      RdHdr:  if (out_bus.rdy) state_d = RdBody;
      RdBody: if (out_bus.rdy && !data_empty && (head_ctrl != '0)) state_d = RdIdle;
      default: state_d = RdIdle;
    endcase
  end

  always_comb begin
    len_pop    = 1'b0;
    data_pop   = 1'b0;
    out_wr_d   = 1'b0;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    unique case (state_q)
      RdIdle: ;
      RdHdr: begin
        if (out_bus.rdy) begin
          len_pop    = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = ioq_hdr(len_head.word_len, SRC_PORT, len_head.byte_len);
          out_ctrl_d = IoQueueStageNum;
        end
      end
      RdBody: begin
        if (out_bus.rdy && !data_empty) begin
          data_pop   = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = head_data;
          out_ctrl_d = head_ctrl;
        end
      end
      default: ;
    endcase
  end

  assign out_bus.data = out_data_q;
  assign out_bus.ctrl = out_ctrl_q;
  assign out_bus.wr   = out_wr_q;

endmodule

// File: tb/tb_ioq_hdr_inserter.sv
// Scoreboard bench: packets are modelled into an expected-word queue, a monitor pops on out_wr.
module tb_ioq_hdr_inserter;

  localparam int unsigned MaxW    = 192;
  localparam logic [15:0] SrcPort = 16'h1234;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    bit          is_hdr;
    bit          chk_gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pkt_truncated;

  ioq_hdr_inserter_if in_if ();
  ioq_hdr_inserter_if out_if ();

  ioq_hdr_inserter #(
    .DATA_WIDTH          (64),
    .CTRL_WIDTH          (8),
    .SRC_PORT            (SrcPort),
    .MAX_PKT_WORDS       (MaxW),
    .DATA_FIFO_DEPTH_BITS(9),
    .LEN_FIFO_DEPTH_BITS (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_bus       (in_if),
    .out_bus      (out_if),
    .pkt_truncated(pkt_truncated)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          rdy_rand = 1'b0;
  int unsigned words_seen = 0;
  int unsigned trunc_cnt = 0;
  int unsigned last_out_cyc = 0;
  int unsigned last_hdr_cyc = 0;
  int unsigned last_wr_cyc = 0;
  logic [63:0] last_hdr_data = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pkt_truncated) trunc_cnt++;
        if (out_if.wr) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h ctrl %h, expected no output", out_if.data,
                     out_if.ctrl);
          end else begin
            e = exp_q.pop_front();
            check64(e.is_hdr ? "hdr_data" : "body_data", out_if.data, e.data);
            check64(e.is_hdr ? "hdr_ctrl" : "body_ctrl", 64'(out_if.ctrl), 64'(e.ctrl));
            if (e.chk_gap) check64("idle_gap", 64'(cyc - last_out_cyc), 64'd2);
            if (e.is_hdr) begin
              last_hdr_cyc  = cyc;
              last_hdr_data = out_if.data;
            end
          end
          last_out_cyc = cyc;
          words_seen++;
        end
      end
      out_if.rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Model the packet into the scoreboard, then drive it honouring in_rdy.
  task automatic send_pkt(input int n, input logic [7:0] lctrl, input bit idle_rand,
                          input bit gap);
    logic [63:0] d[$];
    exp_t        e;
    int          lb, wl, bl, budget;
    bit          tr;
    for (int i = 0; i < n; i++) d.push_back({$urandom, $urandom});
    lb = 0;
    for (int b = 0; b < 8; b++) begin
      if (lctrl[b] && lb == 0) lb = 8 - b;
    end
    tr = (n > int'(MaxW));
    wl = tr ? int'(MaxW) : n;
    bl = tr ? 8 * int'(MaxW) : 8 * (n - 1) + lb;
    e.data    = {16'h0000, 16'(wl), SrcPort, 16'(bl)};
    e.ctrl    = 8'hff;
    e.is_hdr  = 1'b1;
    e.chk_gap = gap;
    exp_q.push_back(e);
    for (int i = 0; i < wl; i++) begin
      e.data    = d[i];
      e.ctrl    = (i == n - 1) ? lctrl : 8'h00;
      if (tr && i == int'(MaxW) - 1) e.ctrl = 8'h01;
      e.is_hdr  = 1'b0;
      e.chk_gap = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (idle_rand && ($urandom_range(0, 3) == 0)) begin
        in_if.wr = 1'b0;
        tick();
      end
      budget = 0;
      while (!in_if.rdy) begin
        in_if.wr = 1'b0;
        tick();
        budget++;
        if (budget > 5000) begin
          $display("FAIL in_rdy_timeout: got in_rdy low for %0d cycles, expected release", budget);
          $fatal(1, "in_rdy stuck low");
        end
      end
      in_if.data = d[i];
      in_if.ctrl = (i == n - 1) ? lctrl : 8'h00;
      in_if.wr   = 1'b1;
      tick();
    end
    in_if.wr    = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    check64("drain_words_left", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
  endtask

  initial begin
    int unsigned t0, base, b;
    logic [7:0]  lc;
    in_if.wr   = 1'b0;
    in_if.data = '0;
    in_if.ctrl = '0;
    out_if.rdy = 1'b1;
    reset      = 1'b1;
    fork
      monitor_loop();
    join_none

    repeat (3) tick();
    check64("rst_out_wr", 64'(out_if.wr), 64'd0);
    check64("rst_out_data", out_if.data, 64'd0);
    check64("rst_out_ctrl", 64'(out_if.ctrl), 64'd0);
    check64("rst_pkt_truncated", 64'(pkt_truncated), 64'd0);
    reset = 1'b0;
    tick();
    check64("rst_in_rdy", 64'(in_if.rdy), 64'd1);

    // 60-byte packet: 7 full words + 4 bytes (lowest ctrl bit 4)
    send_pkt(8, 8'h10, 1'b0, 1'b0);
    wait_drain(200);
    check64("hdr_60B", last_hdr_data, 64'h0000_0008_1234_003C);
    check64("hdr_latency", 64'(last_hdr_cyc - last_wr_cyc), 64'd3);

    send_pkt(1, 8'h80, 1'b0, 1'b0);
    wait_drain(200);
    check64("hdr_1word", last_hdr_data, {16'h0000, 16'd1, SrcPort, 16'd1});
    check64("hdr_1word_latency", 64'(last_hdr_cyc - last_wr_cyc), 64'd3);

    send_pkt(4, 8'h01, 1'b0, 1'b0);
    send_pkt(4, 8'h02, 1'b0, 1'b1);
    send_pkt(4, 8'h40, 1'b0, 1'b1);
    wait_drain(300);

    t0 = trunc_cnt;
    send_pkt(int'(MaxW), 8'h04, 1'b0, 1'b0);
    check64("no_trunc_at_max", 64'(trunc_cnt - t0), 64'd0);
    send_pkt(int'(MaxW) + 5, 8'h80, 1'b0, 1'b0);
    send_pkt(3, 8'h20, 1'b0, 1'b0);
    wait_drain(2000);
    check64("trunc_pulses", 64'(trunc_cnt - t0), 64'd1);

    rdy_rand = 1'b1;
    t0 = trunc_cnt;
    for (int p = 0; p < 200; p++) begin
      lc = 8'((32'($urandom_range(0, 255)) | 32'd1) << $urandom_range(0, 7));
      send_pkt(int'($urandom_range(1, 24)), lc, 1'b1, 1'b0);
    end
    wait_drain(20000);
    rdy_rand = 1'b0;
    check64("random_no_trunc", 64'(trunc_cnt - t0), 64'd0);

    // Reset while the second of three packets is leaving the block
    base = words_seen;
    send_pkt(10, 8'h01, 1'b0, 1'b0);
    send_pkt(10, 8'h02, 1'b0, 1'b0);
    send_pkt(10, 8'h04, 1'b0, 1'b0);
    b = 0;
    while (words_seen < base + 14 && b < 500) begin
      tick();
      b++;
    end
    check64("reached_pkt2_body", 64'(words_seen >= base + 14), 64'd1);
    reset    = 1'b1;
    in_if.wr = 1'b0;
    exp_q.delete();
    tick();
    check64("reset_out_wr", 64'(out_if.wr), 64'd0);
    reset = 1'b0;
    tick();
    send_pkt(6, 8'h08, 1'b0, 1'b0);
    wait_drain(200);
    check64("post_reset_latency", 64'(last_hdr_cyc - last_wr_cyc), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
